// File: rtl/gf12_sram_ctrl_pkg.sv
// Shared defaults, grant encoding and byte-enable expansion for the GF12 SRAM
// request controller (gf12_sram64_be_ctrl and its response FIFO).
package gf12_sram_ctrl_pkg;

    localparam int ADDR_W_DEF = 13;
    localparam int DATA_W_DEF = 64;
    localparam int BE_W_DEF   = DATA_W_DEF / 8;

    typedef enum logic {
        GNT_WRITE = 1'b0,
        GNT_READ  = 1'b1
    } grant_e;

    // The macro masks per bit; each byte enable fans out to its eight bits.
    function automatic logic [DATA_W_DEF-1:0] be_to_bitmask(input logic [BE_W_DEF-1:0] be);
        logic [DATA_W_DEF-1:0] mask;
        mask = {DATA_W_DEF{1'b0}};
        for (int i = 0; i < BE_W_DEF; i++) begin
            mask[8*i +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/gf12_sram_ctrl_rsp_fifo.sv
// In-order read-response buffer: circular DATA_W x RSP_DEPTH store with
// occupancy count. flush_i is the only clear and also serves as reset.
module gf12_sram_ctrl_rsp_fifo
    import gf12_sram_ctrl_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int RSP_DEPTH = 2,
    localparam int CNT_W    = $clog2(RSP_DEPTH + 1),
    localparam int PTR_W    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1
) (
    input  logic              clk_i,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [CNT_W-1:0]  count_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [DATA_W-1:0] head_o
);

    logic [DATA_W-1:0] mem_q [RSP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              do_push_s;
    logic              do_pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_W'(RSP_DEPTH - 1)) begin
            n = {PTR_W{1'b0}};
        end else begin
            n = p + PTR_W'(1);
        end
        return n;
    endfunction

    // Occupancy flags, qualified push/pop and pointer/count next state.
    always_comb begin
        empty_o   = (count_q == {CNT_W{1'b0}});
        full_o    = (count_q == CNT_W'(RSP_DEPTH));
        count_o   = count_q;
        head_o    = mem_q[rd_ptr_q];
        do_pop_s  = pop_i & ~empty_o;
        // A simultaneous pop frees the slot, so a full FIFO may still take a push.
        do_push_s = push_i & (~full_o | do_pop_s);
        wr_ptr_d  = do_push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d  = do_pop_s  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and count; flush empties the buffer.
    always_ff @(posedge clk_i) begin
        if (flush_i) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            for (int i = 0; i < RSP_DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

endmodule

// File: rtl/gf12_sram64_be_ctrl.sv
// Request-side controller for the GF12 13-bit x 64-bit bit-masked SRAM wrapper.
// Optional performance counters are built when GF12_SRAM_CTRL_PERF_EN is defined.
module gf12_sram64_be_ctrl
    import gf12_sram_ctrl_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int RSP_DEPTH = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                rd_req_valid,
    output logic                rd_req_ready,
    input  logic [ADDR_W-1:0]   rd_req_addr,
    output logic                rd_rsp_valid,
    input  logic                rd_rsp_ready,
    output logic [DATA_W-1:0]   rd_rsp_data,
    output logic                CE0,
    output logic [ADDR_W-1:0]   A0,
    output logic [DATA_W-1:0]   D0,
    output logic                WE0,
    output logic [DATA_W-1:0]   WEM0,
    output logic                CE1,
    output logic [ADDR_W-1:0]   A1,
    input  logic [DATA_W-1:0]   Q1
`ifdef GF12_SRAM_CTRL_PERF_EN
    ,
    output logic [31:0]         perf_wr_cnt,
    output logic [31:0]         perf_rd_cnt,
    output logic [31:0]         perf_stall_cnt
`endif
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int CRD_W = CNT_W + 1;

    logic [CNT_W-1:0]  fifo_count_s;
    logic              fifo_empty_s;
    logic              fifo_full_s;
    logic [DATA_W-1:0] fifo_head_s;
    logic              push_s;
    logic              pop_s;
    logic [CRD_W-1:0]  credit_s;
    logic              rd_ok_s;
    logic              wr_elig_s;
    logic              rd_elig_s;
    logic              wr_gnt_s;
    logic              rd_gnt_s;
    logic              wr_access_s;
    logic [DATA_W-1:0] wem_s;
    logic              inflight_q;
    logic              inflight_d;
    grant_e            last_grant_q;
    grant_e            last_grant_d;

    // Response side, read credit and the write/read arbiter.
    always_comb begin
        rd_rsp_valid = ~fifo_empty_s & ~RST;
        pop_s        = rd_rsp_valid & rd_rsp_ready;
        rd_rsp_data  = rd_rsp_valid ? fifo_head_s : {DATA_W{1'b0}};
        // Count the read already in the macro and the slot freed by this cycle's pop.
        credit_s     = CRD_W'(fifo_count_s) + CRD_W'(inflight_q) - CRD_W'(pop_s);
        rd_ok_s      = (credit_s < CRD_W'(RSP_DEPTH));
        wr_elig_s    = wr_valid & ~RST;
        rd_elig_s    = rd_req_valid & rd_ok_s & ~RST;
        wr_gnt_s     = 1'b0;
        rd_gnt_s     = 1'b0;
        if (wr_elig_s && rd_elig_s) begin
            if (last_grant_q == GNT_WRITE) begin
                rd_gnt_s = 1'b1;
            end else begin
                wr_gnt_s = 1'b1;
            end
        end else begin
            wr_gnt_s = wr_elig_s;
            rd_gnt_s = rd_elig_s;
        end
        // An all-zero byte enable completes the handshake without touching the macro.
        wr_access_s  = wr_gnt_s & (wr_be != {(DATA_W/8){1'b0}});
    end

    assign wem_s = DATA_W'(be_to_bitmask(BE_W_DEF'(wr_be)));

    // SRAM pins follow the grant in the same cycle and rest at zero.
    always_comb begin
        wr_ready     = wr_gnt_s;
        rd_req_ready = rd_gnt_s;
        CE0          = wr_access_s;
        WE0          = wr_access_s;
        A0           = wr_access_s ? wr_addr : {ADDR_W{1'b0}};
        D0           = wr_access_s ? wr_data : {DATA_W{1'b0}};
        WEM0         = wr_access_s ? wem_s   : {DATA_W{1'b0}};
        CE1          = rd_gnt_s;
        A1           = rd_gnt_s ? rd_req_addr : {ADDR_W{1'b0}};
    end

    // Next state for the in-flight read marker and the fairness pointer.
    always_comb begin
        inflight_d = rd_gnt_s;
        if (wr_access_s) begin
            last_grant_d = GNT_WRITE;
        end else if (rd_gnt_s) begin
            last_grant_d = GNT_READ;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // In-flight read and last-grant registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            inflight_q   <= 1'b0;
            last_grant_q <= GNT_WRITE;
        end else begin
            inflight_q   <= inflight_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Q1 is captured the cycle after CE1; a read in flight across reset is dropped.
    assign push_s = inflight_q & ~RST;

    gf12_sram_ctrl_rsp_fifo #(
        .DATA_W    (DATA_W),
        .RSP_DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i       (CLK),
        .flush_i     (RST),
        .push_i      (push_s),
        .push_data_i (Q1),
        .pop_i       (pop_s),
        .count_o     (fifo_count_s),
        .empty_o     (fifo_empty_s),
        .full_o      (fifo_full_s),
        .head_o      (fifo_head_s)
    );

`ifdef GF12_SRAM_CTRL_PERF_EN
    logic [31:0] perf_wr_q;
    logic [31:0] perf_wr_d;
    logic [31:0] perf_rd_q;
    logic [31:0] perf_rd_d;
    logic [31:0] perf_stall_q;
    logic [31:0] perf_stall_d;
    logic        stall_s;

    // Counters advance on issued SRAM accesses and on any cycle a valid request waits.
    always_comb begin
        stall_s      = (wr_valid & ~wr_ready) | (rd_req_valid & ~rd_req_ready);
        perf_wr_d    = perf_wr_q + {31'd0, CE0};
        perf_rd_d    = perf_rd_q + {31'd0, CE1};
        perf_stall_d = perf_stall_q + {31'd0, stall_s};
    end

    // Performance counter registers; they wrap naturally at 2^32.
    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_wr_q    <= 32'd0;
            perf_rd_q    <= 32'd0;
            perf_stall_q <= 32'd0;
        end else begin
            perf_wr_q    <= perf_wr_d;
            perf_rd_q    <= perf_rd_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_wr_cnt    = perf_wr_q;
    assign perf_rd_cnt    = perf_rd_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_gf12_sram64_be_ctrl.sv
// Bench for gf12_sram64_be_ctrl: per-cycle vector table for handshakes/strobes,
// a behavioural SRAM on the pins, and a read-data scoreboard.
`timescale 1ns/1ps
module tb_gf12_sram64_be_ctrl;

    localparam int AW = 13;
    localparam int DW = 64;
    localparam int BW = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [BW-1:0] wr_be;
    logic          rd_req_valid;
    logic          rd_req_ready;
    logic [AW-1:0] rd_req_addr;
    logic          rd_rsp_valid;
    logic          rd_rsp_ready;
    logic [DW-1:0] rd_rsp_data;
    logic          CE0;
    logic [AW-1:0] A0;
    logic [DW-1:0] D0;
    logic          WE0;
    logic [DW-1:0] WEM0;
    logic          CE1;
    logic [AW-1:0] A1;
    logic [DW-1:0] Q1;
`ifdef GF12_SRAM_CTRL_PERF_EN
    logic [31:0]   perf_wr_cnt;
    logic [31:0]   perf_rd_cnt;
    logic [31:0]   perf_stall_cnt;
`endif

    always #5 CLK = ~CLK;

    gf12_sram64_be_ctrl dut (
        .CLK(CLK), .RST(RST),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready), .rd_rsp_data(rd_rsp_data),
        .CE0(CE0), .A0(A0), .D0(D0), .WE0(WE0), .WEM0(WEM0),
        .CE1(CE1), .A1(A1), .Q1(Q1)
`ifdef GF12_SRAM_CTRL_PERF_EN
        , .perf_wr_cnt(perf_wr_cnt), .perf_rd_cnt(perf_rd_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    // Behavioural macro driven purely by the DUT pins.
    logic [DW-1:0] sram [int];
    always @(posedge CLK) begin
        if (CE0 && WE0) begin
            sram[int'(A0)] = ((sram.exists(int'(A0)) ? sram[int'(A0)] : 64'd0) & ~WEM0) | (D0 & WEM0);
        end
        if (CE1) begin
            Q1 <= sram.exists(int'(A1)) ? sram[int'(A1)] : 64'd0;
        end
    end

    typedef struct {
        logic          wv;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [BW-1:0] wbe;
        logic          rv;
        logic [AW-1:0] ra;
        logic          rr;
        logic [4:0]    exp;   // {wr_ready, rd_req_ready, CE0, CE1, rd_rsp_valid}
    } vec_t;

    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] exp_q [$];
    vec_t          tbl [$];
    int            n_vec = 0;
    int            n_fail = 0;
    bit            g_rd_hs;
    bit            g_rd_rdy;

    localparam logic [DW-1:0] DA = 64'hA0A1_A2A3_A4A5_A6A7;
    localparam logic [DW-1:0] DB = 64'hB0B1_B2B3_B4B5_B6B7;
    localparam logic [DW-1:0] DC = 64'hC0C1_C2C3_C4C5_C6C7;
    localparam logic [DW-1:0] DD = 64'hD0D1_D2D3_D4D5_D6D7;

    function automatic logic [DW-1:0] mask_of(input logic [BW-1:0] be);
        logic [DW-1:0] m;
        for (int i = 0; i < BW; i++) m[8*i +: 8] = be[i] ? 8'hFF : 8'h00;
        return m;
    endfunction

    function automatic vec_t mk(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                input logic [BW-1:0] wbe, input logic rv, input logic [AW-1:0] ra,
                                input logic rr, input logic [4:0] exp);
        vec_t v;
        v.wv = wv; v.wa = wa; v.wd = wd; v.wbe = wbe;
        v.rv = rv; v.ra = ra; v.rr = rr; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Sampled at the falling edge: pin checks, reference memory and scoreboard.
    task automatic monitor();
        logic [DW-1:0] old;
        g_rd_hs  = rd_req_valid && rd_req_ready;
        g_rd_rdy = rd_req_ready;
        if (RST) begin
            exp_q.delete();
            check("rst_ctl", 64'({wr_ready, rd_req_ready, rd_rsp_valid, CE0, WE0, CE1}), 64'd0);
            check("rst_data", rd_rsp_data, 64'd0);
            check("rst_pins", 64'(|{A0, D0, WEM0, A1}), 64'd0);
            return;
        end
        check("ce_conflict", 64'(CE0 & CE1), 64'd0);
        if (CE0) begin
            check("A0", 64'(A0), 64'(wr_addr));
            check("D0", D0, wr_data);
            check("WEM0", WEM0, mask_of(wr_be));
            check("WE0", 64'(WE0), 64'd1);
        end else begin
            check("idle_wr_pins", 64'(|{A0, D0, WEM0, WE0}), 64'd0);
        end
        if (CE1) check("A1", 64'(A1), 64'(rd_req_addr));
        else     check("idle_A1", 64'(A1), 64'd0);
        if (wr_valid && wr_ready) begin
            old = ref_mem.exists(int'(wr_addr)) ? ref_mem[int'(wr_addr)] : 64'd0;
            ref_mem[int'(wr_addr)] = (old & ~mask_of(wr_be)) | (wr_data & mask_of(wr_be));
        end
        if (rd_req_valid && rd_req_ready)
            exp_q.push_back(ref_mem.exists(int'(rd_req_addr)) ? ref_mem[int'(rd_req_addr)] : 64'd0);
        if (rd_rsp_valid && rd_rsp_ready) begin
            if (exp_q.size() == 0) check("rsp_unexpected", 64'd1, 64'd0);
            else                   check("rd_rsp_data", rd_rsp_data, exp_q.pop_front());
        end
    endtask

    task automatic step(input string tag, input vec_t v, input bit chk);
        wr_valid = v.wv; wr_addr = v.wa; wr_data = v.wd; wr_be = v.wbe;
        rd_req_valid = v.rv; rd_req_addr = v.ra; rd_rsp_ready = v.rr;
        @(negedge CLK);
        monitor();
        if (chk) check($sformatf("hs[%s]", tag),
                       64'({wr_ready, rd_req_ready, CE0, CE1, rd_rsp_valid}), 64'(v.exp));
        @(posedge CLK);
        #1;
    endtask

    initial begin
        automatic vec_t idle = mk(1'b0, 13'd0, 64'd0, 8'h00, 1'b0, 13'd0, 1'b1, 5'b00000);
        automatic logic [AW-1:0] bp_addr [4] = '{13'h020, 13'h021, 13'h022, 13'h023};
        int idx;

        RST = 1'b1;
        repeat (3) step("reset", idle, 1'b0);
        RST = 1'b0;

        // Alternation from reset: first conflict goes to the read.
        tbl.push_back(mk(1, 13'h020, DA, 8'hFF, 1, 13'h020, 1, 5'b01010));
        tbl.push_back(mk(1, 13'h020, DA, 8'hFF, 1, 13'h020, 1, 5'b10100));
        tbl.push_back(mk(1, 13'h021, DB, 8'hFF, 1, 13'h020, 1, 5'b01011));
        tbl.push_back(mk(1, 13'h021, DB, 8'hFF, 1, 13'h021, 1, 5'b10100));
        tbl.push_back(mk(1, 13'h022, DC, 8'hFF, 1, 13'h021, 1, 5'b01011));
        tbl.push_back(mk(1, 13'h022, DC, 8'hFF, 1, 13'h022, 1, 5'b10100));
        tbl.push_back(mk(1, 13'h023, DD, 8'hFF, 1, 13'h022, 1, 5'b01011));
        tbl.push_back(mk(1, 13'h023, DD, 8'hFF, 1, 13'h023, 1, 5'b10100));
        tbl.push_back(mk(0, 13'h000, 64'd0, 8'h00, 1, 13'h023, 1, 5'b01011));
        tbl.push_back(idle);
        tbl.push_back(mk(0, 13'h000, 64'd0, 8'h00, 0, 13'h000, 1, 5'b00001));
        // Full write then read: response two cycles after the read handshake.
        tbl.push_back(mk(1, 13'h0005, 64'hDEADBEEF_01234567, 8'hFF, 0, 13'h000, 1, 5'b10100));
        tbl.push_back(mk(0, 13'h000, 64'd0, 8'h00, 1, 13'h0005, 1, 5'b01010));
        tbl.push_back(idle);
        tbl.push_back(mk(0, 13'h000, 64'd0, 8'h00, 0, 13'h000, 1, 5'b00001));
        // Top address, half-word mask.
        tbl.push_back(mk(1, 13'h1FFF, {64{1'b1}}, 8'hFF, 0, 13'h000, 1, 5'b10100));
        tbl.push_back(mk(1, 13'h1FFF, 64'd0, 8'h0F, 0, 13'h000, 1, 5'b10100));
        tbl.push_back(mk(0, 13'h000, 64'd0, 8'h00, 1, 13'h1FFF, 1, 5'b01010));
        tbl.push_back(idle);
        tbl.push_back(mk(0, 13'h000, 64'd0, 8'h00, 0, 13'h000, 1, 5'b00001));
        // be==0: handshake only, and it does not move the fairness pointer.
        tbl.push_back(mk(1, 13'h1FFF, 64'h1234, 8'h00, 0, 13'h000, 1, 5'b10000));
        tbl.push_back(mk(1, 13'h0006, 64'h0BADF00D_CAFEF00D, 8'hFF, 1, 13'h1FFF, 1, 5'b10100));
        tbl.push_back(mk(0, 13'h000, 64'd0, 8'h00, 1, 13'h1FFF, 1, 5'b01010));
        tbl.push_back(idle);
        tbl.push_back(mk(0, 13'h000, 64'd0, 8'h00, 0, 13'h000, 1, 5'b00001));
        // Sparse byte mask.
        tbl.push_back(mk(1, 13'h0006, 64'h1122_3344_5566_7788, 8'h81, 0, 13'h000, 1, 5'b10100));
        tbl.push_back(mk(0, 13'h000, 64'd0, 8'h00, 1, 13'h0006, 1, 5'b01010));
        tbl.push_back(idle);
        tbl.push_back(mk(0, 13'h000, 64'd0, 8'h00, 0, 13'h000, 1, 5'b00001));

        for (int i = 0; i < tbl.size(); i++) step($sformatf("row%0d", i), tbl[i], 1'b1);

        // Backpressure: with the consumer stalled only two reads fit.
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            step("bp", mk(0, 13'h000, 64'd0, 8'h00, idx < 4, bp_addr[idx % 4], 0, 5'b00000), 1'b0);
            if (g_rd_hs) idx++;
        end
        check("bp_accepted", 64'(idx), 64'd2);
        check("bp_ready_low", 64'(g_rd_rdy), 64'd0);
        for (int c = 0; c < 40 && (idx < 4 || exp_q.size() != 0); c++) begin
            step("drain", mk(0, 13'h000, 64'd0, 8'h00, idx < 4, bp_addr[idx % 4], 1, 5'b00000), 1'b0);
            if (g_rd_hs) idx++;
        end
        check("bp_drain_done", 64'(idx == 4 && exp_q.size() == 0), 64'd1);

        // Reset the cycle after a read handshake: that read must never surface.
        step("rst_rd", mk(0, 13'h000, 64'd0, 8'h00, 1, 13'h0005, 1, 5'b01010), 1'b1);
        RST = 1'b1;
        step("rst_mid", mk(1, 13'h0007, 64'd5, 8'hFF, 1, 13'h0005, 1, 5'b00000), 1'b0);
        RST = 1'b0;
        repeat (4) step("post_rst", idle, 1'b1);
        step("post_rd", mk(0, 13'h000, 64'd0, 8'h00, 1, 13'h0005, 1, 5'b01010), 1'b1);
        step("post_rd1", idle, 1'b1);
        step("post_rd2", mk(0, 13'h000, 64'd0, 8'h00, 0, 13'h000, 1, 5'b00001), 1'b1);
        check("post_rst_sram", ref_mem[13'h0005], 64'hDEADBEEF_01234567);

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, %0d miscompares so far", n_fail);
        $fatal(1);
    end

endmodule
